// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, the NOP
// word, the ROM address width and the mask of address bits that must be zero.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam int ROM_ADDR_W = 9;

    // Bits that must all be clear for a fetch address to be legal:
    // word alignment (bits 1:0) and inside the 512-byte ROM (bits 31:9).
    localparam logic [31:0] ADDR_ZERO_MASK = 32'hFFFF_FE03;

    function automatic logic addr_legal(input logic [31:0] addr);
        return ((addr & ADDR_ZERO_MASK) == 32'h0000_0000);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds the PC, reads one word from the instruction
// ROM after a configurable number of wait states, latches it into ir and
// advances the PC. Illegal fetch addresses park the unit in ERR until the
// control unit loads a new PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic                  pc_load,
    input  logic [31:0]           pc_next,
    output logic                  rom_nce,
    output logic                  rom_re,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [31:0]           rom_data,
    output logic [31:0]           ir,
    output logic [31:0]           pc,
    output logic [31:0]           pc_plus4,
    output logic                  ir_valid,
    output logic                  busy,
    output logic                  fetch_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         ir_valid_q, ir_valid_d;
    logic         rom_nce_q, rom_nce_d;
    logic         rom_re_q, rom_re_d;
    logic [31:0]  fetch_addr;

    // A same-cycle pc_load redirects the fetch, so legality uses pc_next then.
    assign fetch_addr = pc_load ? pc_next : pc_q;

    // Next-state, datapath updates and registered ROM strobes.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        cnt_d      = cnt_q;
        ir_valid_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (pc_load) begin
                    pc_d = pc_next;
                end
                if (fetch_req) begin
                    if (addr_legal(fetch_addr)) begin
                        state_d = ST_ACCESS;
                        cnt_d   = 3'(WAIT_STATES);
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 3'd0) begin
                    ir_d       = rom_data;
                    pc_d       = pc_plus4;
                    ir_valid_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ERR: begin
                if (pc_load) begin
                    pc_d    = pc_next;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rom_nce_d = (state_d != ST_ACCESS);
        rom_re_d  = (state_d == ST_ACCESS);
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= NOP;
            cnt_q      <= 3'd0;
            ir_valid_q <= 1'b0;
            rom_nce_q  <= 1'b1;
            rom_re_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            ir_valid_q <= ir_valid_d;
            rom_nce_q  <= rom_nce_d;
            rom_re_q   <= rom_re_d;
        end
    end

    assign rom_nce   = rom_nce_q;
    assign rom_re    = rom_re_q;
    assign rom_addr  = pc_q[ROM_ADDR_W-1:0];
    assign ir        = ir_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign ir_valid  = ir_valid_q;
    assign busy      = (state_q == ST_ACCESS);
    assign fetch_err = (state_q == ST_ERR);

endmodule
